// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_BAD      = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               pc_write_cond_ne;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_source;
    logic               illegal_op;
    logic               instr_done;
  } strobes_t;

  // DECODE dispatch: instruction class selected by the opcode field.
  function automatic state_e decode_next(input logic [OP_W-1:0] op);
    case (op)
      OP_LW, OP_SW:     return S_MEM_ADDR;
      OP_RTYPE:         return S_R_EXEC;
      OP_ADDI, OP_ANDI: return S_I_EXEC;
      OP_BEQ, OP_BNE:   return S_BRANCH;
      OP_J:             return S_JUMP;
      default:          return S_BAD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the datapath.
interface mc_ctrl_if;
  import mc_ctrl_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               PCWriteCondNe;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         PCSource;
  logic               illegal_op;
  logic               instr_done;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, illegal_op, instr_done, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
           IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, illegal_op, instr_done, state_o
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state/opcode to datapath strobe decoder.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e          state_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            mem_done_i,
  output strobes_t        strobes_c
);

  always_comb begin
    strobes_c = '0;
    case (state_i)
      S_FETCH: begin
        strobes_c.mem_read  = 1'b1;
        strobes_c.alu_src_b = SRCB_FOUR;
        strobes_c.ir_write  = mem_done_i;
        strobes_c.pc_write  = mem_done_i;
      end
      S_DECODE:   strobes_c.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        strobes_c.alu_src_a = 1'b1;
        strobes_c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        strobes_c.mem_read = 1'b1;
        strobes_c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        strobes_c.reg_write  = 1'b1;
        strobes_c.mem_to_reg = 1'b1;
        strobes_c.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        strobes_c.mem_write  = 1'b1;
        strobes_c.i_or_d     = 1'b1;
        strobes_c.instr_done = mem_done_i;
      end
      S_R_EXEC: begin
        strobes_c.alu_src_a = 1'b1;
        strobes_c.alu_src_b = SRCB_B;
        strobes_c.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        strobes_c.reg_write  = 1'b1;
        strobes_c.reg_dst    = 1'b1;
        strobes_c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        strobes_c.alu_src_a        = 1'b1;
        strobes_c.alu_op           = ALUOP_SUB;
        strobes_c.pc_source        = PCSRC_ALUOUT;
        strobes_c.pc_write_cond    = (opcode_i == OP_BEQ);
        strobes_c.pc_write_cond_ne = (opcode_i == OP_BNE);
        strobes_c.instr_done       = 1'b1;
      end
      S_JUMP: begin
        strobes_c.pc_write   = 1'b1;
        strobes_c.pc_source  = PCSRC_JUMP;
        strobes_c.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        strobes_c.alu_src_a = 1'b1;
        strobes_c.alu_src_b = SRCB_IMM;
        strobes_c.alu_op    = (opcode_i == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
      end
      S_I_WB: begin
        strobes_c.reg_write  = 1'b1;
        strobes_c.instr_done = 1'b1;
      end
      S_BAD: begin
        strobes_c.illegal_op = 1'b1;
        strobes_c.instr_done = 1'b1;
      end
      default: strobes_c = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with variable-latency memory handshake.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  state_e   state_q, state_d;
  strobes_t strobes_c, strobes_o;
  logic     mem_done_c;

  // With waiting disabled every memory access completes in one cycle.
  assign mem_done_c = !MEM_WAIT_EN || bus.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_done_c) state_d = S_DECODE;
      S_DECODE:   state_d = decode_next(bus.opcode);
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_done_c) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_done_c) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state_i    (state_q),
    .opcode_i   (bus.opcode),
    .mem_done_i (mem_done_c),
    .strobes_c  (strobes_c)
  );

  // Reset forces every strobe low so an abandoned instruction writes nothing.
  always_comb begin
    strobes_o = strobes_c;
    if (rst) strobes_o = '0;
  end

  assign bus.PCWrite       = strobes_o.pc_write;
  assign bus.PCWriteCond   = strobes_o.pc_write_cond;
  assign bus.PCWriteCondNe = strobes_o.pc_write_cond_ne;
  assign bus.IorD          = strobes_o.i_or_d;
  assign bus.MemRead       = strobes_o.mem_read;
  assign bus.MemWrite      = strobes_o.mem_write;
  assign bus.IRWrite       = strobes_o.ir_write;
  assign bus.MemtoReg      = strobes_o.mem_to_reg;
  assign bus.RegDst        = strobes_o.reg_dst;
  assign bus.RegWrite      = strobes_o.reg_write;
  assign bus.ALUSrcA       = strobes_o.alu_src_a;
  assign bus.ALUSrcB       = strobes_o.alu_src_b;
  assign bus.ALUOp         = strobes_o.alu_op;
  assign bus.PCSource      = strobes_o.pc_source;
  assign bus.illegal_op    = strobes_o.illegal_op;
  assign bus.instr_done    = strobes_o.instr_done;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected cycle traces vs. two DUT variants.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] op;
    logic       rdy;
    logic       pcw, pcwc, pcwne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       ill, done;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op_r = '0;
  logic       mr0 = 1'b0, mr1 = 1'b0;
  int         checks = 0, errors = 0;
  cyc_t       exp_q[$];
  cyc_t       obs0, obs1;

  always #5 clk = ~clk;

  mc_ctrl_if bus0();
  mc_ctrl_if bus1();
  assign bus0.opcode = op_r;
  assign bus0.mem_ready = mr0;
  assign bus1.opcode = op_r;
  assign bus1.mem_ready = mr1;

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut_wait (.clk(clk), .rst(rst), .bus(bus0));
  multicycle_control #(.MEM_WAIT_EN(1'b0)) dut_nowait (.clk(clk), .rst(rst), .bus(bus1));

  always_comb begin
    obs0 = '0;
    obs0.st = bus0.state_o; obs0.pcw = bus0.PCWrite; obs0.pcwc = bus0.PCWriteCond;
    obs0.pcwne = bus0.PCWriteCondNe; obs0.iord = bus0.IorD; obs0.mrd = bus0.MemRead;
    obs0.mwr = bus0.MemWrite; obs0.irw = bus0.IRWrite; obs0.m2r = bus0.MemtoReg;
    obs0.rdst = bus0.RegDst; obs0.rw = bus0.RegWrite; obs0.srca = bus0.ALUSrcA;
    obs0.srcb = bus0.ALUSrcB; obs0.aluop = bus0.ALUOp; obs0.pcsrc = bus0.PCSource;
    obs0.ill = bus0.illegal_op; obs0.done = bus0.instr_done;
  end

  always_comb begin
    obs1 = '0;
    obs1.st = bus1.state_o; obs1.pcw = bus1.PCWrite; obs1.pcwc = bus1.PCWriteCond;
    obs1.pcwne = bus1.PCWriteCondNe; obs1.iord = bus1.IorD; obs1.mrd = bus1.MemRead;
    obs1.mwr = bus1.MemWrite; obs1.irw = bus1.IRWrite; obs1.m2r = bus1.MemtoReg;
    obs1.rdst = bus1.RegDst; obs1.rw = bus1.RegWrite; obs1.srca = bus1.ALUSrcA;
    obs1.srcb = bus1.ALUSrcB; obs1.aluop = bus1.ALUOp; obs1.pcsrc = bus1.PCSource;
    obs1.ill = bus1.illegal_op; obs1.done = bus1.instr_done;
  end

  function automatic cyc_t blank(input logic [3:0] st, input logic [5:0] op);
    cyc_t c = '0;
    c.st  = st;
    c.op  = op;
    c.rdy = 1'($urandom);
    return c;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, by instruction class.
  task automatic push_instr(input logic [5:0] op, input int wf, input int wm);
    cyc_t c;
    for (int i = 0; i <= wf; i++) begin
      c = blank(4'd0, 6'($urandom));
      c.mrd = 1'b1; c.srcb = 2'b01;
      c.rdy = (i == wf);
      c.irw = (i == wf); c.pcw = (i == wf);
      exp_q.push_back(c);
    end
    c = blank(4'd1, op); c.srcb = 2'b11; exp_q.push_back(c);
    case (op)
      6'b100011, 6'b101011: begin
        c = blank(4'd2, op); c.srca = 1'b1; c.srcb = 2'b10; exp_q.push_back(c);
        for (int i = 0; i <= wm; i++) begin
          c = blank((op == 6'b100011) ? 4'd3 : 4'd5, op);
          c.iord = 1'b1; c.rdy = (i == wm);
          if (op == 6'b100011) c.mrd = 1'b1;
          else begin c.mwr = 1'b1; c.done = (i == wm); end
          exp_q.push_back(c);
        end
        if (op == 6'b100011) begin
          c = blank(4'd4, op); c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1; exp_q.push_back(c);
        end
      end
      6'b000000: begin
        c = blank(4'd6, op); c.srca = 1'b1; c.aluop = 2'b10; exp_q.push_back(c);
        c = blank(4'd7, op); c.rw = 1'b1; c.rdst = 1'b1; c.done = 1'b1; exp_q.push_back(c);
      end
      6'b001000, 6'b001100: begin
        c = blank(4'd10, op); c.srca = 1'b1; c.srcb = 2'b10;
        c.aluop = (op == 6'b001100) ? 2'b11 : 2'b00; exp_q.push_back(c);
        c = blank(4'd11, op); c.rw = 1'b1; c.done = 1'b1; exp_q.push_back(c);
      end
      6'b000100, 6'b000101: begin
        c = blank(4'd8, op); c.srca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
        c.pcwc = (op == 6'b000100); c.pcwne = (op == 6'b000101); c.done = 1'b1;
        exp_q.push_back(c);
      end
      6'b000010: begin
        c = blank(4'd9, op); c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; exp_q.push_back(c);
      end
      default: begin
        c = blank(4'd12, op); c.ill = 1'b1; c.done = 1'b1; exp_q.push_back(c);
      end
    endcase
  endtask

  // Plays the queued trace; called at posedge+1 with the selected DUT in FETCH.
  task automatic run_trace(input string name, input int which, input bit hold_mr1_low);
    cyc_t e, got;
    int   cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      op_r = e.op;
      mr0  = e.rdy;
      mr1  = hold_mr1_low ? 1'b0 : e.rdy;
      @(negedge clk);
      got = (which == 0) ? obs0 : obs1;
      got.op = e.op;
      got.rdy = e.rdy;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got state=%0d strobes=%h, expected state=%0d strobes=%h",
                 name, cyc, got.st, got[16:0], e.st, e[16:0]);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc_t zero = '0;
    rst = 1'b1; mr0 = 1'b1; mr1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      op_r = 6'($urandom);
      @(negedge clk);
      checks++;
      if (obs0 !== zero) begin
        errors++;
        $display("FAIL reset_outputs: got %h, expected %h", obs0, zero);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    push_instr(6'b100011, 0, 0);
    run_trace("reset_then_lw", 0, 1'b0);
  endtask

  task automatic test_lw();
    push_instr(6'b100011, 0, 0);
    run_trace("lw_nowait", 0, 1'b0);
    push_instr(6'b100011, 2, 1);
    run_trace("lw_waits", 0, 1'b0);
  endtask

  task automatic test_sw_wait();
    push_instr(6'b101011, 0, 3);
    run_trace("sw_wait3", 0, 1'b0);
  endtask

  task automatic test_branches();
    push_instr(6'b000100, 0, 0);
    run_trace("beq", 0, 1'b0);
    push_instr(6'b000101, 0, 0);
    run_trace("bne", 0, 1'b0);
    push_instr(6'b000010, 1, 0);
    run_trace("jump", 0, 1'b0);
  endtask

  task automatic test_illegal();
    push_instr(6'b111111, 0, 0);
    run_trace("illegal", 0, 1'b0);
    push_instr(6'b000000, 0, 0);
    run_trace("rtype_after_bad", 0, 1'b0);
  endtask

  task automatic test_nowait();
    do_reset();
    push_instr(6'b001000, 0, 0);
    run_trace("nowait_addi", 1, 1'b1);
    push_instr(6'b001100, 0, 0);
    void'(exp_q.pop_back());
    run_trace("nowait_andi", 1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.state_o !== 4'd11 || bus1.RegWrite !== 1'b0 || bus1.instr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_iwb: got state=%0d RegWrite=%b done=%b, expected 11 0 0",
               bus1.state_o, bus1.RegWrite, bus1.instr_done);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus1.state_o !== 4'd0 || bus1.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_iwb: got state=%0d RegWrite=%b, expected 0 0",
               bus1.state_o, bus1.RegWrite);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal [8];
    logic [5:0] op;
    int         idx;
    legal[0] = 6'b100011; legal[1] = 6'b101011; legal[2] = 6'b000000; legal[3] = 6'b001000;
    legal[4] = 6'b001100; legal[5] = 6'b000100; legal[6] = 6'b000101; legal[7] = 6'b000010;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 9));
      op  = (idx < 8) ? legal[idx] : 6'($urandom);
      push_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    run_trace("random_b2b", 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branches();
    test_illegal();
    test_nowait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
